// File: rtl/snd_cmd_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : snd_cmd_queue                                                    |
// | Purpose  : Buffers main-CPU sound writes and replays them to the sound      |
// |            board as timed sndstart pulses separated by an enforced gap.     |
// | Options  : SNDQ_DEDUP_EN - drop a push that repeats the current FIFO tail.  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module snd_cmd_queue #(
  parameter int DEPTH_LOG2  = 2,
  parameter int HOLD_CYCLES = 64,
  parameter int GAP_CYCLES  = 16384
) (
  input  logic                  clk8M,
  input  logic                  reset,
  input  logic                  cpu_wr_snd,
  input  logic [7:0]            cpu_do,
  input  logic                  ovf_clr,
  output logic [7:0]            sndno,
  output logic                  sndstart,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  overflow
);

  localparam int c_DEPTH   = 1 << DEPTH_LOG2;
  localparam int c_CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0]    c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]    c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0]   c_FULL_LVL  = (DEPTH_LOG2+1)'(c_DEPTH);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = DEPTH_LOG2'(1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ASSERT = 2'd1;
  localparam logic [1:0] c_SPACE  = 2'd2;

  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic                  r_wr_prev;
  logic [1:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;

  logic                  w_wr_edge;
  logic                  w_pop;
  logic                  w_dup;
  logic                  w_room;
  logic                  w_push;
  logic                  w_drop;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  assign w_wr_edge = cpu_wr_snd & ~r_wr_prev;
  assign w_pop     = (r_state == c_IDLE) && (level != '0);

`ifdef SNDQ_DEDUP_EN
  logic [DEPTH_LOG2-1:0] w_tail_ptr;
  assign w_tail_ptr = r_wr_ptr - c_PTR_ONE;
  assign w_dup      = (level != '0) && (cpu_do == r_mem[w_tail_ptr]);
`else
  assign w_dup      = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full queue can still accept the write.
  assign w_room = !full || w_pop;
  assign w_push = w_wr_edge && !w_dup && w_room;
  assign w_drop = w_wr_edge && !w_dup && !w_room;

  always_comb begin
    w_level_nxt = level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = level + 1'b1;
      2'b01:   w_level_nxt = level - 1'b1;
      default: w_level_nxt = level;
    endcase
  end

  always_ff @(posedge clk8M) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cpu_do;
    end
  end

  always_ff @(posedge clk8M or negedge reset) begin
    if (!reset) begin
      r_wr_prev <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      level     <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_wr_prev <= cpu_wr_snd;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      level <= w_level_nxt;
      full  <= (w_level_nxt == c_FULL_LVL);
      if (w_drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Pulse sequencer: HOLD_CYCLES high, then GAP_CYCLES low before the next pop.
  always_ff @(posedge clk8M or negedge reset) begin
    if (!reset) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      sndno    <= 8'h00;
      sndstart <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            sndno    <= r_mem[r_rd_ptr];
            sndstart <= 1'b1;
            r_cnt    <= c_HOLD_LOAD;
            r_state  <= c_ASSERT;
          end
        end
        c_ASSERT: begin
          if (r_cnt == '0) begin
            sndstart <= 1'b0;
            r_cnt    <= c_GAP_LOAD;
            r_state  <= c_SPACE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_SPACE: begin
          if (r_cnt == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          sndstart <= 1'b0;
          r_state  <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snd_cmd_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_snd_cmd_queue                                                 |
// | Purpose  : Directed self-checking bench for snd_cmd_queue (short timings).  |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_snd_cmd_queue;

  localparam int DEPTH_LOG2 = 2;
  localparam int HOLD       = 8;
  localparam int GAP        = 20;
  localparam int RISE_GAP   = HOLD + GAP + 1;

  logic                clk8M      = 1'b0;
  logic                reset      = 1'b1;
  logic                cpu_wr_snd = 1'b0;
  logic [7:0]          cpu_do     = 8'h00;
  logic                ovf_clr    = 1'b0;
  logic [7:0]          sndno;
  logic                sndstart;
  logic [DEPTH_LOG2:0] level;
  logic                full;
  logic                overflow;

  always #5 clk8M = ~clk8M;

  snd_cmd_queue #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk8M      (clk8M),
    .reset      (reset),
    .cpu_wr_snd (cpu_wr_snd),
    .cpu_do     (cpu_do),
    .ovf_clr    (ovf_clr),
    .sndno      (sndno),
    .sndstart   (sndstart),
    .level      (level),
    .full       (full),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Pulse observer: records rise cycle, command number and high length of every pulse.
  int   cyc = 0;
  int   rise_cyc[$];
  int   rise_no[$];
  int   hi_len[$];
  int   hi_cnt = 0;
  logic mon_prev = 1'b0;

  always @(posedge clk8M) cyc <= cyc + 1;

  always @(negedge clk8M) begin
    if (sndstart && !mon_prev) begin
      rise_cyc.push_back(cyc);
      rise_no.push_back(int'(sndno));
      hi_cnt = 0;
    end
    if (sndstart) hi_cnt++;
    else if (mon_prev) hi_len.push_back(hi_cnt);
    mon_prev = sndstart;
  end

  function automatic int get_no(input int i);
    return (i < rise_no.size()) ? rise_no[i] : -1;
  endfunction
  function automatic int get_cyc(input int i);
    return (i < rise_cyc.size()) ? rise_cyc[i] : -1;
  endfunction
  function automatic int get_len(input int i);
    return (i < hi_len.size()) ? hi_len[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk8M);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    cpu_do     = d;
    cpu_wr_snd = 1'b1;
    tick();
    cpu_wr_snd = 1'b0;
    tick();
  endtask

  task automatic wait_fall(input string name);
    int n = 0;
    while (sndstart !== 1'b1 && n < 200) begin tick(); n++; end
    while (sndstart === 1'b1 && n < 200) begin tick(); n++; end
    check({name, " fall within bound"}, int'(n < 200), 1);
  endtask

  task automatic check_state(input string name, input int e_no, input int e_start,
                             input int e_lvl, input int e_full, input int e_ovf);
    check({name, " sndno"},    int'(sndno),    e_no);
    check({name, " sndstart"}, int'(sndstart), e_start);
    check({name, " level"},    int'(level),    e_lvl);
    check({name, " full"},     int'(full),     e_full);
    check({name, " overflow"}, int'(overflow), e_ovf);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       clr;
    logic [7:0] e_no;
    logic       e_start;
    int         e_lvl;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int hb;
    int exp_lvl;

    // Single write: push, then pop one edge later; long strobe and data change ignored.
    tbl[0] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h99, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h99, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h5A, 1'b1, 0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h22, 1'b0, 8'h5A, 1'b1, 1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h5A, 1'b1, 1, 1'b0, 1'b0};

    #2 reset = 1'b0;
    #1;
    check_state("reset", 0, 0, 0, 0, 0);
    repeat (3) tick();
    check_state("reset clocked", 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // Test 1: table-driven single write and push during ASSERT
    b  = rise_cyc.size();
    hb = hi_len.size();
    for (int i = 0; i < 8; i++) begin
      cpu_wr_snd = tbl[i].wr;
      cpu_do     = tbl[i].d;
      ovf_clr    = tbl[i].clr;
      tick();
      check_state($sformatf("t1[%0d]", i), int'(tbl[i].e_no), int'(tbl[i].e_start),
                  tbl[i].e_lvl, int'(tbl[i].e_full), int'(tbl[i].e_ovf));
    end
    cpu_wr_snd = 1'b0;
    ovf_clr    = 1'b0;
    tick();
    check("t1 high last cycle", int'(sndstart), 1);
    tick();
    check("t1 low after hold", int'(sndstart), 0);
    check("t1 sndno held", int'(sndno), 8'h5A);
    repeat (60) tick();
    check("t1 pulse count", rise_cyc.size() - b, 2);
    check("t1 no0", get_no(b), 8'h5A);
    check("t1 no1", get_no(b + 1), 8'h22);
    check("t1 spacing", get_cyc(b + 1) - get_cyc(b), RISE_GAP);
    check("t1 hold len0", get_len(hb), HOLD);
    check("t1 hold len1", get_len(hb + 1), HOLD);
    check("t1 level empty", int'(level), 0);

    // Test 2: three back-to-back writes replayed in order
    b  = rise_cyc.size();
    hb = hi_len.size();
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    check("t2 level after writes", int'(level), 2);
    repeat (3 * RISE_GAP + 10) tick();
    check("t2 pulse count", rise_cyc.size() - b, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2 no%0d", i), get_no(b + i), i + 1);
      check($sformatf("t2 len%0d", i), get_len(hb + i), HOLD);
    end
    check("t2 spacing01", get_cyc(b + 1) - get_cyc(b), RISE_GAP);
    check("t2 spacing12", get_cyc(b + 2) - get_cyc(b + 1), RISE_GAP);
    check_state("t2 end", 8'h03, 0, 0, 0, 0);

    // Test 3: overflow while sequencer sits in SPACE
    b = rise_cyc.size();
    wr(8'h0F);
    wait_fall("t3");
    for (int i = 0; i < 6; i++) begin
      wr(8'h10 + 8'(i));
      if (i == 3) check_state("t3 after 4th", 8'h0F, 0, 4, 1, 0);
      if (i == 4) check("t3 ovf after 5th", int'(overflow), 1);
    end
    check_state("t3 after 6th", 8'h0F, 0, 4, 1, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3 ovf cleared", int'(overflow), 0);
    cpu_do     = 8'h16;
    cpu_wr_snd = 1'b1;
    ovf_clr    = 1'b1;
    tick();
    cpu_wr_snd = 1'b0;
    ovf_clr    = 1'b0;
    check("t3 set beats clear", int'(overflow), 1);
    check("t3 level still full", int'(level), 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3 ovf cleared again", int'(overflow), 0);
    check("t3 still in gap", int'(sndstart), 0);
    repeat (5 * RISE_GAP + 10) tick();
    check("t3 pulse count", rise_cyc.size() - b, 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3 no%0d", i), get_no(b + i), (i == 0) ? 8'h0F : 8'h0F + i);
    check_state("t3 end", 8'h13, 0, 0, 0, 0);

    // Test 4: write into a full queue on the very edge the sequencer pops
    b = rise_cyc.size();
    wr(8'h40);
    wait_fall("t4");
    for (int i = 1; i <= 4; i++) wr(8'h40 + 8'(i));
    check("t4 level full", int'(level), 4);
    check("t4 full flag", int'(full), 1);
    repeat (12) tick();
    check_state("t4 before pop", 8'h40, 0, 4, 1, 0);
    cpu_do     = 8'h77;
    cpu_wr_snd = 1'b1;
    tick();
    cpu_wr_snd = 1'b0;
    check_state("t4 pop+push", 8'h41, 1, 4, 1, 0);
    repeat (6 * RISE_GAP + 10) tick();
    check("t4 pulse count", rise_cyc.size() - b, 6);
    check("t4 second to last", get_no(b + 4), 8'h44);
    check("t4 last", get_no(b + 5), 8'h77);
    check_state("t4 end", 8'h77, 0, 0, 0, 0);

    // Test 5: asynchronous reset in the middle of a pulse
    wr(8'h66);
    wr(8'h67);
    wr(8'h68);
    check("t5 pre-reset sndstart", int'(sndstart), 1);
    check("t5 pre-reset level", int'(level), 2);
    #2 reset = 1'b0;
    #1;
    check_state("t5 async reset", 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b1;
    b = rise_cyc.size();
    repeat (40) tick();
    check("t5 no pulse after release", rise_cyc.size() - b, 0);
    check_state("t5 idle", 0, 0, 0, 0, 0);
    wr(8'h55);
    check("t5 new write sndstart", int'(sndstart), 1);
    check("t5 new write sndno", int'(sndno), 8'h55);
    repeat (RISE_GAP + 5) tick();

    // Test 6: repeated value pushed onto a non-empty queue
`ifdef SNDQ_DEDUP_EN
    exp_lvl = 2;
`else
    exp_lvl = 3;
`endif
    b = rise_cyc.size();
    wr(8'h2E);
    wr(8'h30);
    wr(8'h30);
    wr(8'h31);
    check("t6 level", int'(level), exp_lvl);
    check("t6 overflow", int'(overflow), 0);
    repeat ((exp_lvl + 1) * RISE_GAP + 10) tick();
    check("t6 pulse count", rise_cyc.size() - b, exp_lvl + 1);
    check("t6 no1", get_no(b + 1), 8'h30);
    check("t6 last", get_no(b + exp_lvl), 8'h31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
